// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 set-2 scan-code to ASCII decoder.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK
    } ps2_state_t;

    localparam logic [7:0] SC_BREAK   = 8'hF0;
    localparam logic [7:0] SC_EXT     = 8'hE0;
    localparam logic [7:0] SC_SHIFT_L = 8'h12;
    localparam logic [7:0] SC_SHIFT_R = 8'h59;
    localparam logic [7:0] SC_CTRL    = 8'h14;
    localparam logic [7:0] SC_CAPS    = 8'h58;
    localparam logic [7:0] SC_ENTER   = 8'h5A;
    localparam logic [7:0] SC_NULL    = 8'h00;
    localparam logic [7:0] SC_ERR     = 8'hFF;
    localparam logic [7:0] SC_BAT     = 8'hAA;

    localparam logic [6:0] ASC_BS  = 7'h08;
    localparam logic [6:0] ASC_TAB = 7'h09;
    localparam logic [6:0] ASC_CR  = 7'h0D;
    localparam logic [6:0] ASC_ESC = 7'h1B;

    function automatic logic is_letter(input logic [6:0] c);
        return (c >= 7'h41 && c <= 7'h5A) || (c >= 7'h61 && c <= 7'h7A);
    endfunction

endpackage

// File: rtl/ps2_ascii_lut.sv
// Combinational US-layout set-2 lookup: {shift, caps, code} -> {hit, ascii}.
module ps2_ascii_lut
    import ps2_pkg::*;
(
    input  logic       shift,
    input  logic       caps,
    input  logic [7:0] code,
    output logic       hit,
    output logic [6:0] ascii
);

    logic [6:0] norm;
    logic [6:0] shf;
    logic       letter;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        hit = 1'b1;
        {norm, shf} = 14'h0;
        case (code)
            8'h1C: {norm, shf} = {7'h61, 7'h41};
            8'h32: {norm, shf} = {7'h62, 7'h42};
            8'h21: {norm, shf} = {7'h63, 7'h43};
            8'h23: {norm, shf} = {7'h64, 7'h44};
            8'h24: {norm, shf} = {7'h65, 7'h45};
            8'h2B: {norm, shf} = {7'h66, 7'h46};
            8'h34: {norm, shf} = {7'h67, 7'h47};
            8'h33: {norm, shf} = {7'h68, 7'h48};
            8'h43: {norm, shf} = {7'h69, 7'h49};
            8'h3B: {norm, shf} = {7'h6A, 7'h4A};
            8'h42: {norm, shf} = {7'h6B, 7'h4B};
            8'h4B: {norm, shf} = {7'h6C, 7'h4C};
            8'h3A: {norm, shf} = {7'h6D, 7'h4D};
            8'h31: {norm, shf} = {7'h6E, 7'h4E};
            8'h44: {norm, shf} = {7'h6F, 7'h4F};
            8'h4D: {norm, shf} = {7'h70, 7'h50};
            8'h15: {norm, shf} = {7'h71, 7'h51};
            8'h2D: {norm, shf} = {7'h72, 7'h52};
            8'h1B: {norm, shf} = {7'h73, 7'h53};
            8'h2C: {norm, shf} = {7'h74, 7'h54};
            8'h3C: {norm, shf} = {7'h75, 7'h55};
            8'h2A: {norm, shf} = {7'h76, 7'h56};
            8'h1D: {norm, shf} = {7'h77, 7'h57};
            8'h22: {norm, shf} = {7'h78, 7'h58};
            8'h35: {norm, shf} = {7'h79, 7'h59};
            8'h1A: {norm, shf} = {7'h7A, 7'h5A};
            8'h16: {norm, shf} = {7'h31, 7'h21};
            8'h1E: {norm, shf} = {7'h32, 7'h40};
            8'h26: {norm, shf} = {7'h33, 7'h23};
            8'h25: {norm, shf} = {7'h34, 7'h24};
            8'h2E: {norm, shf} = {7'h35, 7'h25};
            8'h36: {norm, shf} = {7'h36, 7'h5E};
            8'h3D: {norm, shf} = {7'h37, 7'h26};
            8'h3E: {norm, shf} = {7'h38, 7'h2A};
            8'h46: {norm, shf} = {7'h39, 7'h28};
            8'h45: {norm, shf} = {7'h30, 7'h29};
            8'h0E: {norm, shf} = {7'h60, 7'h7E};
            8'h4E: {norm, shf} = {7'h2D, 7'h5F};
            8'h55: {norm, shf} = {7'h3D, 7'h2B};
            8'h54: {norm, shf} = {7'h5B, 7'h7B};
            8'h5B: {norm, shf} = {7'h5D, 7'h7D};
            8'h5D: {norm, shf} = {7'h5C, 7'h7C};
            8'h4C: {norm, shf} = {7'h3B, 7'h3A};
            8'h52: {norm, shf} = {7'h27, 7'h22};
            8'h41: {norm, shf} = {7'h2C, 7'h3C};
            8'h49: {norm, shf} = {7'h2E, 7'h3E};
            8'h4A: {norm, shf} = {7'h2F, 7'h3F};
            8'h29: {norm, shf} = {7'h20, 7'h20};
            8'h66: {norm, shf} = {ASC_BS, ASC_BS};
            8'h0D: {norm, shf} = {ASC_TAB, ASC_TAB};
            8'h76: {norm, shf} = {ASC_ESC, ASC_ESC};
            8'h5A: {norm, shf} = {ASC_CR, ASC_CR};
            default: hit = 1'b0;
        endcase
    end

    // Only letters have their unshifted form in a..z; they alone honour Caps Lock.
    assign letter = (norm >= 7'h61) && (norm <= 7'h7A);
    assign ascii  = (letter ? (shift ^ caps) : shift) ? shf : norm;

endmodule

// File: rtl/ps2_ascii_decoder.sv
// PS/2 set-2 decoder: prefix FSM, modifier tracking and output FIFO.
// Optional Ctrl-letter control codes enabled by defining PS2_CTRL_CODES_EN.
module ps2_ascii_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH    = 8,
    parameter bit EMIT_ON_BREAK = 1'b0
) (
    input  logic                        Clock,
    input  logic                        Reset,
    input  logic [7:0]                  ScanCode,
    input  logic                        ScanValid,
    output logic [6:0]                  Ascii,
    output logic                        AsciiValid,
    input  logic                        AsciiReady,
    output logic                        CapsLed,
    output logic                        ShiftActive,
    output logic                        Overflow,
    output logic [$clog2(FIFO_DEPTH):0] Level
);

    localparam int AW = $clog2(FIFO_DEPTH);

    ps2_state_t state, state_nx;
    logic       key_make, key_break, key_ext;
    logic       shift_l, shift_r, caps_led, caps_held;
    logic       lut_hit;
    logic [6:0] lut_ascii;
    logic       push;
    logic [6:0] push_char;

    // NOTE: state register uses non-blocking assignment; next-state logic is a separate combinational process.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        key_make  = 1'b0;
        key_break = 1'b0;
        key_ext   = 1'b0;
        if (ScanValid) begin
            if (ScanCode == SC_NULL || ScanCode == SC_ERR || ScanCode == SC_BAT) begin
                state_nx = ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (ScanCode == SC_BREAK)    state_nx = ST_BRK;
                        else if (ScanCode == SC_EXT) state_nx = ST_EXT;
                        else                         key_make = 1'b1;
                    end
                    ST_BRK: begin
                        key_break = 1'b1;
                        state_nx  = ST_IDLE;
                    end
                    ST_EXT: begin
                        if (ScanCode == SC_BREAK) begin
                            state_nx = ST_EXT_BRK;
                        end else begin
                            key_make = 1'b1;
                            key_ext  = 1'b1;
                            state_nx = ST_IDLE;
                        end
                    end
                    default: begin
                        key_break = 1'b1;
                        key_ext   = 1'b1;
                        state_nx  = ST_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef PS2_CTRL_CODES_EN
    logic ctrl;
`endif

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            shift_l   <= 1'b0;
            shift_r   <= 1'b0;
            caps_led  <= 1'b0;
            caps_held <= 1'b0;
`ifdef PS2_CTRL_CODES_EN
            ctrl      <= 1'b0;
`endif
        end else if (key_make || key_break) begin
            if (!key_ext && ScanCode == SC_SHIFT_L) shift_l <= key_make;
            if (!key_ext && ScanCode == SC_SHIFT_R) shift_r <= key_make;
            // Typematic repeats of Caps arrive while held and must not re-toggle.
            if (!key_ext && ScanCode == SC_CAPS) begin
                if (key_make && !caps_held) caps_led <= ~caps_led;
                caps_held <= key_make;
            end
`ifdef PS2_CTRL_CODES_EN
            if (ScanCode == SC_CTRL) ctrl <= key_make;
`endif
        end
    end

    assign ShiftActive = shift_l | shift_r;
    assign CapsLed     = caps_led;

    ps2_ascii_lut u_lut (
        .shift (ShiftActive),
        .caps  (caps_led),
        .code  (ScanCode),
        .hit   (lut_hit),
        .ascii (lut_ascii)
    );

    always_comb begin
        push      = 1'b0;
        push_char = lut_ascii;
        if (EMIT_ON_BREAK ? key_break : key_make) begin
            if (key_ext) begin
                push      = (ScanCode == SC_ENTER);
                push_char = ASC_CR;
            end else begin
`ifdef PS2_CTRL_CODES_EN
                if (ctrl) begin
                    push      = lut_hit && is_letter(lut_ascii);
                    push_char = {2'b00, lut_ascii[4:0]};
                end else begin
                    push = lut_hit;
                end
`else
                push = lut_hit;
`endif
            end
        end
    end

    logic [6:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, pop, do_push;

    assign full    = (count == (AW + 1)'(FIFO_DEPTH));
    assign pop     = (count != '0) && AsciiReady;
    assign do_push = push && (!full || pop);

    // NOTE: storage array is not reset; only pointers and count carry state that matters after reset.
    always_ff @(posedge Clock) begin
        if (do_push) mem[wr_ptr] <= push_char;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            Overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            Overflow <= push && full && !pop;
        end
    end

    assign AsciiValid = (count != '0);
    assign Ascii      = AsciiValid ? mem[rd_ptr] : 7'h00;
    assign Level      = count;

endmodule

// File: tb/tb_ps2_ascii_decoder.sv
// Directed bench: make-mode DUT (a) and break-mode DUT (b) sharing one clock.
module tb_ps2_ascii_decoder;

    logic       Clock = 1'b0;
    logic       reset_a, reset_b;
    logic [7:0] code_a, code_b;
    logic       valid_a, valid_b, ready_a, ready_b;
    logic [6:0] ascii_a, ascii_b;
    logic       avalid_a, avalid_b, caps_a, caps_b, shift_a, shift_b, ovf_a, ovf_b;
    logic [3:0] level_a, level_b;

    int passed = 0;
    int total  = 0;

    always #5 Clock = ~Clock;

    ps2_ascii_decoder #(.FIFO_DEPTH(8), .EMIT_ON_BREAK(1'b0)) dut_a (
        .Clock(Clock), .Reset(reset_a), .ScanCode(code_a), .ScanValid(valid_a),
        .Ascii(ascii_a), .AsciiValid(avalid_a), .AsciiReady(ready_a), .CapsLed(caps_a),
        .ShiftActive(shift_a), .Overflow(ovf_a), .Level(level_a)
    );

    ps2_ascii_decoder #(.FIFO_DEPTH(8), .EMIT_ON_BREAK(1'b1)) dut_b (
        .Clock(Clock), .Reset(reset_b), .ScanCode(code_b), .ScanValid(valid_b),
        .Ascii(ascii_b), .AsciiValid(avalid_b), .AsciiReady(ready_b), .CapsLed(caps_b),
        .ShiftActive(shift_b), .Overflow(ovf_b), .Level(level_b)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send_a(input logic [7:0] b);
        @(negedge Clock);
        code_a  = b;
        valid_a = 1'b1;
        @(negedge Clock);
        valid_a = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] b);
        @(negedge Clock);
        code_b  = b;
        valid_b = 1'b1;
        @(negedge Clock);
        valid_b = 1'b0;
    endtask

    initial begin
        reset_a = 1'b1; reset_b = 1'b1;
        code_a = 8'h00; code_b = 8'h00;
        valid_a = 1'b0; valid_b = 1'b0;
        ready_a = 1'b1; ready_b = 1'b1;
        repeat (3) @(negedge Clock);
        reset_a = 1'b0; reset_b = 1'b0;

        // Reset state
        check("rst_ascii", ascii_a, 8'h00);
        check("rst_valid", avalid_a, 8'h0);
        check("rst_caps", caps_a, 8'h0);
        check("rst_shift", shift_a, 8'h0);
        check("rst_ovf", ovf_a, 8'h0);
        check("rst_level", level_a, 8'h0);

        // Plain make, then break produces nothing
        send_a(8'h1C);
        check("a_valid", avalid_a, 8'h1);
        check("a_char", ascii_a, 8'h61);
        @(negedge Clock);
        check("a_popped", avalid_a, 8'h0);
        send_a(8'hF0); send_a(8'h1C);
        check("break_silent", avalid_a, 8'h0);

        // Shift and Caps interaction
        send_a(8'h12);
        check("shift_held", shift_a, 8'h1);
        send_a(8'h1C);
        check("shift_A", ascii_a, 8'h41);
        send_a(8'hF0); send_a(8'h1C);
        send_a(8'hF0); send_a(8'h12);
        check("shift_rel", shift_a, 8'h0);
        send_a(8'h58); send_a(8'hF0); send_a(8'h58);
        check("caps_on", caps_a, 8'h1);
        send_a(8'h1C);
        check("caps_A", ascii_a, 8'h41);
        send_a(8'h12); send_a(8'h1C);
        check("shift_caps_a", ascii_a, 8'h61);
        send_a(8'hF0); send_a(8'h12);
        send_a(8'h16);
        check("digit_1", ascii_a, 8'h31);
        send_a(8'h59); send_a(8'h1E);
        check("shiftr_at", ascii_a, 8'h40);
        send_a(8'hF0); send_a(8'h59);

        // Caps typematic toggles once
        send_a(8'h58);
        check("caps_tog1", caps_a, 8'h0);
        send_a(8'h58); send_a(8'h58);
        check("caps_typematic", caps_a, 8'h0);
        send_a(8'hF0); send_a(8'h58);
        check("caps_release", caps_a, 8'h0);

        // Extended codes
        send_a(8'hE0); send_a(8'h5A);
        check("ext_enter", ascii_a, 8'h0D);
        send_a(8'hE0); send_a(8'h75);
        check("ext_unmapped", avalid_a, 8'h0);
        send_a(8'h1C);
        check("after_ext", ascii_a, 8'h61);
        send_a(8'hE0); send_a(8'hAA); send_a(8'h1C);
        check("aa_resync", ascii_a, 8'h61);

        // Reset in the middle of a prefix
        send_a(8'hE0);
        @(negedge Clock); reset_a = 1'b1;
        @(negedge Clock); reset_a = 1'b0;
        send_a(8'h1C);
        check("rst_mid_prefix", ascii_a, 8'h61);

        // Ctrl codes (configuration dependent)
        send_a(8'h14); send_a(8'h21);
`ifdef PS2_CTRL_CODES_EN
        check("ctrl_c", ascii_a, 8'h03);
`else
        check("ctrl_c", ascii_a, 8'h63);
`endif
        send_a(8'hF0); send_a(8'h14);
        send_a(8'hE0); send_a(8'h14); send_a(8'h1A);
`ifdef PS2_CTRL_CODES_EN
        check("rctrl_z", ascii_a, 8'h1A);
`else
        check("rctrl_z", ascii_a, 8'h7A);
`endif
        send_a(8'hE0); send_a(8'hF0); send_a(8'h14);
        send_a(8'h21);
        check("ctrl_released", ascii_a, 8'h63);

        // FIFO fill, overflow, simultaneous push/pop, drain
        @(negedge Clock);
        ready_a = 1'b0;
        for (int i = 0; i < 8; i++) send_a(8'h1C);
        check("fill_level", level_a, 8'h8);
        check("fill_no_ovf", ovf_a, 8'h0);
        send_a(8'h1C);
        check("ovf_pulse", ovf_a, 8'h1);
        check("ovf_level", level_a, 8'h8);
        @(negedge Clock);
        check("ovf_one_cycle", ovf_a, 8'h0);
        code_a = 8'h32; valid_a = 1'b1; ready_a = 1'b1;
        @(negedge Clock);
        valid_a = 1'b0; ready_a = 1'b0;
        check("pushpop_level", level_a, 8'h8);
        check("pushpop_ovf", ovf_a, 8'h0);
        check("pushpop_head", ascii_a, 8'h61);
        ready_a = 1'b1;
        repeat (7) @(negedge Clock);
        check("drain_tail", ascii_a, 8'h62);
        @(negedge Clock);
        check("drain_level", level_a, 8'h0);
        check("drain_ascii", ascii_a, 8'h00);

        // Break-mode DUT
        check("b_rst_valid", avalid_b, 8'h0);
        send_b(8'h1C);
        check("b_make1", avalid_b, 8'h0);
        send_b(8'h1C);
        check("b_make2", avalid_b, 8'h0);
        send_b(8'hF0);
        check("b_f0", avalid_b, 8'h0);
        send_b(8'h1C);
        check("b_break_valid", avalid_b, 8'h1);
        check("b_break_char", ascii_b, 8'h61);
        @(negedge Clock);
        check("b_once", avalid_b, 8'h0);
        send_b(8'hE0); send_b(8'h5A);
        check("b_ext_make", avalid_b, 8'h0);
        send_b(8'hE0); send_b(8'hF0); send_b(8'h5A);
        check("b_ext_break", ascii_b, 8'h0D);
        send_b(8'hE0);
        @(negedge Clock); reset_b = 1'b1;
        @(negedge Clock); reset_b = 1'b0;
        send_b(8'h1C);
        check("b_rst_make", avalid_b, 8'h0);
        send_b(8'hF0); send_b(8'h1C);
        check("b_rst_break", ascii_b, 8'h61);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
